// File: rtl/gemm_pkg.sv
// Shared types for the result collector: FP16 result word, collector FSM states,
// and the width of the tile id tag on the merged stream.
package gemm_pkg;
    typedef logic [15:0] result_fp16_t;
    typedef enum logic [1:0] {IDLE, SELECT, DRAIN, DONE} collector_state_e;
    localparam int RESULT_TILE_ID_W = 4;
endpackage

// File: rtl/result_tile_fifo.sv
// Per-tile first-word-fall-through FIFO with a registered almost-full flag.
// A push into a full FIFO is accepted only when the same cycle pops.
module result_tile_fifo
    import gemm_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  result_fp16_t din,
    input  logic         pop,
    output result_fp16_t dout,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty,
    output logic         afull
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH    = CW'(DEPTH - AFULL_MARGIN);

    result_fp16_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            afull  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
            // Registered from the current count, so it trails the count by a cycle.
            afull <= (count >= AF_TH);
        end
    end
endmodule

// File: rtl/result_collector.sv
// Buffers each tile's result stream and re-serialises them tile-major
// (lowest enabled tile first) into a single registered output stream.
module result_collector
    import gemm_pkg::*;
#(
    parameter int NUM_TILES    = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [NUM_TILES-1:0]        i_column_enable,
    input  logic [15:0]                 i_results_per_tile,
    input  logic [NUM_TILES-1:0]        i_tile_result_valid,
    input  logic [16*NUM_TILES-1:0]     i_tile_result_data,
    output logic [NUM_TILES-1:0]        o_tile_afull,
    output result_fp16_t                o_result_data,
    output logic                        o_result_valid,
    output logic [RESULT_TILE_ID_W-1:0] o_result_tile_id,
    input  logic                        i_result_full,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    collector_state_e state, next;
    logic [NUM_TILES-1:0]        en_mask, rem_mask;
    logic [15:0]                 cnt_lat, emit_cnt;
    logic [RESULT_TILE_ID_W-1:0] cur_tile, low_idx;
    logic                        start_go, do_pop, tile_done, drop_err, leftover;

    logic [NUM_TILES-1:0]           acc, pop, f_full, f_empty, f_afull;
    logic [NUM_TILES-1:0][15:0]     f_dout;
    logic [NUM_TILES-1:0][CW-1:0]   f_count;

    assign o_busy       = (state != IDLE);
    assign o_tile_afull = f_afull;

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        assign acc[t] = i_tile_result_valid[t] && o_busy && en_mask[t];
        assign pop[t] = do_pop && (cur_tile == RESULT_TILE_ID_W'(t));
        result_tile_fifo #(.DEPTH(FIFO_DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) u_fifo (
            .clk   (i_clk),
            .reset (i_reset),
            .flush (start_go),
            .push  (acc[t]),
            .din   (i_tile_result_data[16*t +: 16]),
            .pop   (pop[t]),
            .dout  (f_dout[t]),
            .count (f_count[t]),
            .full  (f_full[t]),
            .empty (f_empty[t]),
            .afull (f_afull[t])
        );
    end

    always_comb begin
        low_idx = '0;
        for (int t = NUM_TILES - 1; t >= 0; t--)
            if (rem_mask[t]) low_idx = RESULT_TILE_ID_W'(t);
    end

    always_comb begin
        leftover = 1'b0;
        for (int t = 0; t < NUM_TILES; t++)
            if (f_count[t] != '0) leftover = 1'b1;
    end

    // Drops: valid outside a round or for a disabled tile, or push into a full FIFO with no pop.
    assign drop_err = |(i_tile_result_valid & ~acc) || |(acc & f_full & ~pop);

    always_comb begin
        next      = state;
        start_go  = 1'b0;
        do_pop    = 1'b0;
        tile_done = 1'b0;
        case (state)
            IDLE:   if (i_start) begin
                        start_go = 1'b1;
                        next     = SELECT;
                    end
            SELECT: next = (rem_mask == '0) ? DONE : DRAIN;
            DRAIN:  if (cnt_lat == '0) begin
                        tile_done = 1'b1;
                        next      = SELECT;
                    end else if (!f_empty[cur_tile] && !i_result_full) begin
                        do_pop = 1'b1;
                        if (emit_cnt == cnt_lat - 16'd1) begin
                            tile_done = 1'b1;
                            next      = SELECT;
                        end
                    end
            DONE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= IDLE;
            en_mask          <= '0;
            rem_mask         <= '0;
            cnt_lat          <= '0;
            emit_cnt         <= '0;
            cur_tile         <= '0;
            o_result_valid   <= 1'b0;
            o_result_data    <= '0;
            o_result_tile_id <= '0;
            o_done           <= 1'b0;
            o_error          <= 1'b0;
        end else begin
            state <= next;
            if (start_go) begin
                en_mask  <= i_column_enable;
                rem_mask <= i_column_enable;
                cnt_lat  <= i_results_per_tile;
            end
            if (state == SELECT && rem_mask != '0) begin
                cur_tile <= low_idx;
                emit_cnt <= '0;
            end
            if (do_pop)    emit_cnt <= emit_cnt + 16'd1;
            if (tile_done) rem_mask[cur_tile] <= 1'b0;
            o_result_valid <= do_pop;
            if (do_pop) begin
                o_result_data    <= f_dout[cur_tile];
                o_result_tile_id <= cur_tile;
            end
            o_done <= (state == DONE);
            if (start_go)
                o_error <= 1'b0;
            else if (drop_err || (state == DONE && leftover))
                o_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: tile-major order, backpressure, overflow,
// empty/zero-count rounds, full-FIFO push+pop and mid-round reset.
module tb_result_collector;
    localparam int NT = 16;

    logic              clk = 1'b0;
    logic              i_reset, i_start, i_result_full;
    logic [NT-1:0]     i_column_enable, i_tile_result_valid, o_tile_afull;
    logic [15:0]       i_results_per_tile, o_result_data;
    logic [16*NT-1:0]  i_tile_result_data;
    logic              o_result_valid, o_busy, o_done, o_error;
    logic [3:0]        o_result_tile_id;

    int tests = 0, fails = 0;
    logic [15:0] q_data[$];
    logic [3:0]  q_id[$];

    always #5 clk = ~clk;

    result_collector #(.NUM_TILES(NT), .FIFO_DEPTH(16), .AFULL_MARGIN(4)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_column_enable(i_column_enable), .i_results_per_tile(i_results_per_tile),
        .i_tile_result_valid(i_tile_result_valid), .i_tile_result_data(i_tile_result_data),
        .o_tile_afull(o_tile_afull), .o_result_data(o_result_data),
        .o_result_valid(o_result_valid), .o_result_tile_id(o_result_tile_id),
        .i_result_full(i_result_full), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always @(negedge clk) begin
        if (o_result_valid) begin
            q_data.push_back(o_result_data);
            q_id.push_back(o_result_tile_id);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [15:0] m, input logic [15:0] c);
        i_column_enable    = m;
        i_results_per_tile = c;
        i_start            = 1'b1;
        @(negedge clk);
        i_start            = 1'b0;
    endtask

    task automatic drive(input int t, input logic [15:0] v);
        i_tile_result_valid    = '0;
        i_tile_result_valid[t] = 1'b1;
        i_tile_result_data[16*t +: 16] = v;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (o_done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("done_timeout", 0, 1);
    endtask

    // Expect n consecutive values base, base+1, ... all tagged with id.
    task automatic chk_q(input string tag, input logic [15:0] base, input int n, input logic [3:0] id);
        chk({tag, "_n"}, q_data.size(), n);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), q_data[i], base + 16'(i));
            chk($sformatf("%s_id%0d", tag, i), q_id[i], id);
        end
    endtask

    initial begin
        int n, viol;
        i_reset = 1'b1; i_start = 1'b0; i_result_full = 1'b0;
        i_column_enable = '0; i_results_per_tile = '0;
        i_tile_result_valid = '0; i_tile_result_data = '0;
        tick(3);
        chk("rst_ctl", {o_busy, o_done, o_result_valid, o_error}, 0);
        chk("rst_data", {o_result_data, o_result_tile_id}, 0);
        chk("rst_afull", o_tile_afull, 0);
        i_reset = 1'b0;
        tick(1);

        // Empty mask: done exactly three cycles after the start edge.
        q_data.delete(); q_id.delete();
        i_column_enable = '0; i_results_per_tile = 16'd1; i_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            chk($sformatf("mask0_done%0d", k), o_done, (k == 2));
            chk($sformatf("mask0_busy%0d", k), o_busy, (k < 2));
        end
        chk("mask0_novalid", q_data.size(), 0);

        // Zero count, two tiles: SELECT/DRAIN per tile then SELECT, DONE, o_done.
        start(16'h0006, 16'd0);
        wait_done(n);
        chk("zero_cnt_lat", n, 6);
        chk("zero_cnt_err", o_error, 0);
        tick(1);

        // Tile-major reordering: tile 2 delivers before tile 0.
        q_data.delete(); q_id.delete();
        start(16'h0005, 16'd3);
        for (int i = 0; i < 3; i++) begin drive(2, 16'h2000 + 16'(i)); tick(1); end
        for (int i = 0; i < 3; i++) begin drive(0, 16'h0000 + 16'(i)); tick(1); end
        i_tile_result_valid = '0;
        wait_done(n);
        tick(1);
        chk("reord_n", q_data.size(), 6);
        for (int i = 0; i < 6 && i < q_data.size(); i++) begin
            chk($sformatf("reord_d%0d", i), q_data[i], (i < 3) ? 16'(i) : 16'h2000 + 16'(i - 3));
            chk($sformatf("reord_id%0d", i), q_id[i], (i < 3) ? 0 : 2);
        end
        chk("reord_err", o_error, 0);

        // Backpressure: full over cycles 4..8 blocks output in cycles 5..9.
        q_data.delete(); q_id.delete();
        start(16'h0001, 16'd8);
        viol = 0;
        for (int i = 0; i < 15; i++) begin
            if (i >= 5 && i <= 9 && o_result_valid) viol++;
            if (i < 8) drive(0, 16'h1000 + 16'(i)); else i_tile_result_valid = '0;
            i_result_full = (i >= 4 && i <= 8);
            tick(1);
        end
        wait_done(n);
        tick(1);
        chk("bp_gap", viol, 0);
        chk_q("bp", 16'h1000, 8, 4'd0);
        chk("bp_err", o_error, 0);

        // Overflow on tile 3 with the output stalled.
        q_data.delete(); q_id.delete();
        i_result_full = 1'b1;
        start(16'h0008, 16'd16);
        for (int i = 0; i < 18; i++) begin
            if (i == 12) chk("ovf_afull_c12", o_tile_afull[3], 0);
            if (i == 13) chk("ovf_afull_c13", o_tile_afull[3], 1);
            if (i == 16) chk("ovf_err_pre", o_error, 0);
            if (i == 17) chk("ovf_err_post", o_error, 1);
            if (i < 17) drive(3, 16'h3000 + 16'(i)); else i_tile_result_valid = '0;
            tick(1);
        end
        i_result_full = 1'b0;
        wait_done(n);
        tick(1);
        chk_q("ovf", 16'h3000, 16, 4'd3);
        chk("ovf_err_sticky", o_error, 1);

        // Full FIFO with simultaneous push and pop from cycle 16 on.
        q_data.delete(); q_id.delete();
        i_result_full = 1'b1;
        start(16'h0010, 16'd20);
        for (int i = 0; i < 20; i++) begin
            if (i == 18) chk("pp_afull_hold", o_tile_afull[4], 1);
            drive(4, 16'h4000 + 16'(i));
            i_result_full = (i < 16);
            tick(1);
        end
        i_tile_result_valid = '0;
        wait_done(n);
        tick(1);
        chk_q("pp", 16'h4000, 20, 4'd4);
        chk("pp_err", o_error, 0);

        // Reset while draining tile 1, then a clean round on tile 1.
        start(16'h0003, 16'd4);
        for (int i = 0; i < 4; i++) begin drive(0, 16'h5000 + 16'(i)); tick(1); end
        drive(1, 16'h5100); tick(1);
        i_tile_result_valid = '0;
        tick(8);
        chk("mid_busy", o_busy, 1);
        i_reset = 1'b1;
        tick(1);
        chk("mid_rst_ctl", {o_busy, o_done, o_result_valid, o_error}, 0);
        chk("mid_rst_data", {o_result_data, o_result_tile_id}, 0);
        chk("mid_rst_afull", o_tile_afull, 0);
        i_reset = 1'b0;
        tick(1);
        q_data.delete(); q_id.delete();
        start(16'h0002, 16'd2);
        for (int i = 0; i < 2; i++) begin drive(1, 16'h6100 + 16'(i)); tick(1); end
        i_tile_result_valid = '0;
        wait_done(n);
        tick(1);
        chk_q("mid_new", 16'h6100, 2, 4'd1);
        chk("mid_new_err", o_error, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
